count_drain: RTL and testbench
==============================

COUNT_DRAIN -- requirements
Module: count_drain

Interface
REQ-001 Parameter INIT_SIZE, default 230: size value restored at reset.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset; sampled only on posedge clk.
REQ-004 selector  input  1  drain enable; one decrement per cycle while asserted and eligible.
REQ-005 load  input  1  single-cycle request to reload the counters from load_size.
REQ-006 load_size  input  8  new size value, sampled when load=1.
REQ-007 x  output  8  registered drain index.
REQ-008 y  output  8  registered drain count.
REQ-009 size  output  8  registered bound; changes only on reset or load.
REQ-010 busy  output  1  registered; 1 exactly while state is DRAIN.
REQ-011 done  output  1  registered; 1 exactly while state is DONE.

Function
REQ-012 FSM states SHALL be DRAIN and DONE only; no other encoding reachable.
REQ-013 In DRAIN, with selector=1 and x>1, x and y SHALL each decrement by 1 next cycle and size SHALL hold.
REQ-014 In DRAIN, with selector=0, x, y and size SHALL hold.
REQ-015 In DRAIN, a decrement that makes x equal 1 SHALL move state to DONE on the same edge.
REQ-016 In DRAIN with x==1 already (empty load), state SHALL move to DONE on the next edge regardless of selector.
REQ-017 In DONE, x, y and size SHALL hold; selector SHALL be ignored.
REQ-018 load=1 in any state SHALL set size<=L, y<=L, x<=L+1, state<=DRAIN, where L = load_size, except load_size=255 SHALL be clamped to L=254 so x never wraps.
REQ-019 load and selector asserted together: load SHALL win; no decrement that cycle.
REQ-020 All arithmetic 8-bit unsigned; x SHALL never go below 1 and never wrap past 255.
REQ-021 Invariants SHALL hold on every cycle after reset: y == x-1; y <= size; x <= size+1; done implies (x==1 and y==0).
REQ-022 Latency: a decrement is visible on outputs one cycle after the enabling edge; busy/done reflect the state register with no combinational path from inputs.

Reset
REQ-023 rst=1 SHALL set x=INIT_SIZE+1 (231), y=INIT_SIZE (230), size=INIT_SIZE (230), state=DRAIN, busy=1, done=0.
REQ-024 rst SHALL take priority over load and selector on the same edge.
REQ-025 rst asserted mid-drain or in DONE SHALL restore the full reset values on the next edge, discarding progress.

Structure
REQ-026 Shared package count_pkg SHALL hold the state enum (DRAIN, DONE) and the default INIT_SIZE constant used by the counter blocks.
REQ-027 Single module; no sub-module is natural at this size.
REQ-028 Outputs busy and done SHALL be decoded from the state register only.

Verification
REQ-029 rst 1 cycle, then selector=1 for 230 cycles -> x steps 231..1, y 230..0, done=1 on the cycle x reaches 1, busy=0.
REQ-030 From reset, selector toggled 1,0,1 -> x=229, y=228 after three cycles; hold on the 0 cycle.
REQ-031 load=1 load_size=0 -> x=1, y=0, size=0, busy=1; next cycle done=1 with selector=0.
REQ-032 load=1 load_size=255 -> size=254, y=254, x=255; 254 selector cycles reach x=1, no wrap.
REQ-033 load=1 and selector=1 same cycle with load_size=5 -> x=6, y=5 (no decrement); rst asserted after 3 drains -> x=231, y=230, size=230.
REQ-034 Bench SHALL check REQ-021 invariants every cycle in all scenarios.

Source files
------------

// File: rtl/count_pkg.sv
// Shared types and constants for the count/drain counter block.
package count_pkg;

  typedef enum logic {
    DRAIN = 1'b0,
    DONE  = 1'b1
  } state_e;

  localparam int unsigned INIT_SIZE_DEF = 230;
  localparam int unsigned CNT_W         = 8;

  // Largest size that keeps x = size+1 inside 8 bits.
  localparam logic [CNT_W-1:0] SIZE_MAX = 8'd254;

  function automatic logic [CNT_W-1:0] clamp_size(input logic [CNT_W-1:0] l);
    return (l == 8'hFF) ? SIZE_MAX : l;
  endfunction

endpackage

// File: rtl/count_drain.sv
// Drain counter: x counts down toward 1 (y tracks x-1) while selector is high,
// then parks in DONE until reset or a new load.
module count_drain
  import count_pkg::*;
#(
  parameter int unsigned INIT_SIZE = INIT_SIZE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       selector,
  input  logic       load,
  input  logic [7:0] load_size,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic [7:0] size,
  output logic       busy,
  output logic       done
);

  state_e     state, state_nxt;
  logic [7:0] x_nxt, y_nxt, size_nxt;
  logic [7:0] ld_l;

  assign ld_l = clamp_size(load_size);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DRAIN;
      x     <= 8'(INIT_SIZE + 1);
      y     <= 8'(INIT_SIZE);
      size  <= 8'(INIT_SIZE);
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
      size  <= size_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    size_nxt  = size;
    if (load) begin
      // Load beats selector; no decrement in the load cycle.
      state_nxt = DRAIN;
      size_nxt  = ld_l;
      y_nxt     = ld_l;
      x_nxt     = ld_l + 8'd1;
    end else begin
      unique case (state)
        DRAIN: begin
          if (x == 8'd1) begin
            state_nxt = DONE;
          end else if (selector) begin
            x_nxt = x - 8'd1;
            y_nxt = y - 8'd1;
            if (x == 8'd2) state_nxt = DONE;
          end
        end
        DONE: ;
        default: state_nxt = DRAIN;
      endcase
    end
  end

  assign busy = (state == DRAIN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_count_drain.sv
// Directed bench for count_drain: hand-computed vectors plus per-cycle invariants.
module tb_count_drain;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       selector = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_size = 8'd0;
  logic [7:0] x, y, size;
  logic       busy, done;

  int vectors = 0;
  int miscompares = 0;
  bit inv_on = 1'b0;

  count_drain #(.INIT_SIZE(230)) dut (
    .clk(clk), .rst(rst), .selector(selector), .load(load), .load_size(load_size),
    .x(x), .y(y), .size(size), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_inv();
    chk("inv_y_eq_xm1", {24'd0, y}, {24'd0, x - 8'd1});
    chk("inv_y_le_size", {31'd0, y <= size}, 32'd1);
    chk("inv_x_le_size1", {31'd0, 9'(x) <= 9'(size) + 9'd1}, 32'd1);
    chk("inv_done_xy", {31'd0, !done || (x == 8'd1 && y == 8'd0)}, 32'd1);
    chk("inv_busy_ndone", {31'd0, busy ^ done}, 32'd1);
  endtask

  // Advance one edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    if (inv_on) chk_inv();
  endtask

  task automatic chk_out(input string tag, input logic [7:0] ex, input logic [7:0] ey,
                         input logic [7:0] es, input logic eb, input logic ed);
    chk({tag, "_x"}, {24'd0, x}, {24'd0, ex});
    chk({tag, "_y"}, {24'd0, y}, {24'd0, ey});
    chk({tag, "_size"}, {24'd0, size}, {24'd0, es});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, eb});
    chk({tag, "_done"}, {31'd0, done}, {31'd0, ed});
  endtask

  initial begin
    // Reset state
    #2;
    rst = 1'b1; selector = 1'b1; load = 1'b1; load_size = 8'd9;
    step();
    inv_on = 1'b1;
    chk_out("reset", 8'd231, 8'd230, 8'd230, 1'b1, 1'b0);
    rst = 1'b0; load = 1'b0; selector = 1'b0;
    step();
    chk_out("idle_hold", 8'd231, 8'd230, 8'd230, 1'b1, 1'b0);

    // Selector 1,0,1
    selector = 1'b1; step(); chk_out("tog1", 8'd230, 8'd229, 8'd230, 1'b1, 1'b0);
    selector = 1'b0; step(); chk_out("tog0", 8'd230, 8'd229, 8'd230, 1'b1, 1'b0);
    selector = 1'b1; step(); chk_out("tog2", 8'd229, 8'd228, 8'd230, 1'b1, 1'b0);

    // Full drain from reset
    rst = 1'b1; step(); rst = 1'b0;
    chk_out("rst2", 8'd231, 8'd230, 8'd230, 1'b1, 1'b0);
    selector = 1'b1;
    for (int i = 1; i <= 230; i++) begin
      step();
      chk("drain_x", {24'd0, x}, 32'(231 - i));
      chk("drain_done", {31'd0, done}, {31'd0, i == 230});
    end
    chk_out("drained", 8'd1, 8'd0, 8'd230, 1'b0, 1'b1);
    step(); step();
    chk_out("done_hold", 8'd1, 8'd0, 8'd230, 1'b0, 1'b1);

    // Empty load, then done without selector
    selector = 1'b0; load = 1'b1; load_size = 8'd0;
    step(); load = 1'b0;
    chk_out("load0", 8'd1, 8'd0, 8'd0, 1'b1, 1'b0);
    step();
    chk_out("load0_done", 8'd1, 8'd0, 8'd0, 1'b0, 1'b1);

    // Clamped max load, drain without wrap
    load = 1'b1; load_size = 8'd255;
    step(); load = 1'b0;
    chk_out("load255", 8'd255, 8'd254, 8'd254, 1'b1, 1'b0);
    selector = 1'b1;
    for (int i = 1; i <= 254; i++) begin
      step();
      chk("d255_x", {24'd0, x}, 32'(255 - i));
    end
    chk_out("d255_end", 8'd1, 8'd0, 8'd254, 1'b0, 1'b1);
    step();
    chk_out("d255_hold", 8'd1, 8'd0, 8'd254, 1'b0, 1'b1);

    // Load wins over selector; drain to done; rst mid-drain
    load = 1'b1; load_size = 8'd5; selector = 1'b1;
    step(); load = 1'b0;
    chk_out("ld_sel", 8'd6, 8'd5, 8'd5, 1'b1, 1'b0);
    step(); step(); step();
    chk_out("ld_3dr", 8'd3, 8'd2, 8'd5, 1'b1, 1'b0);
    rst = 1'b1; load = 1'b1; load_size = 8'd7;
    step(); rst = 1'b0; load = 1'b0;
    chk_out("rst_mid", 8'd231, 8'd230, 8'd230, 1'b1, 1'b0);

    // Drain a small load to exactly 1, then reload from DONE
    load = 1'b1; load_size = 8'd3; selector = 1'b0;
    step(); load = 1'b0; selector = 1'b1;
    step(); chk_out("s3_1", 8'd3, 8'd2, 8'd3, 1'b1, 1'b0);
    step(); chk_out("s3_2", 8'd2, 8'd1, 8'd3, 1'b1, 1'b0);
    step(); chk_out("s3_3", 8'd1, 8'd0, 8'd3, 1'b0, 1'b1);
    load = 1'b1; load_size = 8'd10;
    step(); load = 1'b0;
    chk_out("reload_done", 8'd11, 8'd10, 8'd10, 1'b1, 1'b0);
    step();
    chk_out("reload_dr", 8'd10, 8'd9, 8'd10, 1'b1, 1'b0);

    // Reset out of DONE
    load = 1'b1; load_size = 8'd1;
    step(); load = 1'b0;
    step();
    chk_out("ld1_done", 8'd1, 8'd0, 8'd1, 1'b0, 1'b1);
    rst = 1'b1; step(); rst = 1'b0; selector = 1'b0;
    chk_out("rst_done", 8'd231, 8'd230, 8'd230, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
